row_packer: RTL and testbench
=============================

# row_packer

Upstream stage of `median_filter`: it converts a raster pixel stream, one 24-bit RGB pixel per accepted beat, into full-width rows for the filter's `row_in`. It assembles `COL` pixels per row, then presents the row on a valid/ready output held in a one-deep output register. It tracks the row position in the frame and flags the first row, which drives the filter's `SET` (load-first-row) sequencing, and the last row.

## Interface
- `ROW`, 256, rows per frame
- `COL`, 256, pixels per row
- `WIDTH`, 8, bits per colour component; pixel width `PIX = 3*WIDTH`
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `pix_in`  in  PIX  pixel, R in [PIX-1 -: WIDTH], G middle, B in [WIDTH-1:0]
- `pix_valid`  in  1  `pix_in`/`sof` valid
- `sof`  in  1  start of frame, qualified by `pix_valid`; marks pixel (row 0, col 0)
- `pix_ready`  out  1  pixel accepted when `pix_valid && pix_ready`
- `row_out`  out  COL*PIX  packed row; pixel j at bits [COL*PIX-1-PIX*j -: PIX], so pixel 0 is at the MSBs
- `row_valid`  out  1  `row_out` holds a complete row
- `row_ready`  in  1  consumer takes the row when `row_valid && row_ready`
- `row_num`  out  clog2(ROW)  frame row index of `row_out`
- `row_first`  out  1  `row_out` is frame row 0; the integrator drives the filter's `SET` low for this row
- `row_last`  out  1  `row_out` is frame row ROW-1
- `sof_err`  out  1  one-cycle pulse, `sof` accepted while col ≠ 0

## Operation
- Internal state:
  - `col` counter 0..COL-1
  - `row` counter 0..ROW-1
  - assembly register `asm` (COL*PIX bits)
  - `asm_full` flag
  - output register (`row_out`, `row_valid`, `row_num`, `row_first`, `row_last`)
- Accept: write `pix_in` into `asm` slot `col`, then increment `col`.
- `pix_ready = !asm_full` (combinational).
- Row completion happens on acceptance at col = COL-1. `col` wraps to 0 and `row` increments, wrapping ROW-1 → 0.
  - If the output slot is free (`!row_valid || row_ready`): on the same edge the output register loads `asm` including this pixel, together with row metadata.
  - Otherwise: set `asm_full`, so `pix_ready` goes low.
- While `asm_full`: when the slot frees (`row_ready` high with `row_valid`), load the output from `asm`, clear `asm_full`, keep `row_valid` at 1.
- Consume with no new row: `row_valid` → 0. `row_out` keeps its last value.
- `sof` accepted:
  - Pixel is forced to col 0, row 0, and any partial row is discarded.
  - If col ≠ 0 before the beat, pulse `sof_err` next cycle.
  - A row already in the output register or in `asm` (full) is unaffected.
- Pixels without a prior `sof` after reset start at row 0, col 0.
- `row_first = (row_num == 0)`, `row_last = (row_num == ROW-1)`, both registered with the row.
- `row_out` is stable while `row_valid && !row_ready`.

## Timing
- Reset values:
  - `row_out` = 0, `row_valid` = 0, `row_num` = 0, `row_first` = 0, `row_last` = 0, `sof_err` = 0.
  - `asm_full` = 0, so `pix_ready` = 1 once reset state is established.
  - `col` = 0, `row` = 0.
  - `asm` contents are don't-care.
- Latency: `row_valid` rises on the edge that accepts the row's last pixel, i.e. visible the cycle after that beat.
- Throughput: one pixel per cycle sustained. With `row_ready` held high, back-to-back rows every COL cycles with no bubble.
- Backpressure: at most two rows are buffered (output plus `asm`). `pix_ready` falls the cycle after the second row's last pixel is accepted. It rises the cycle after the output row is consumed.
- Simultaneous events:
  - Consume and last-pixel acceptance in the same cycle: new row loads, `row_valid` stays 1, no bubble.
  - `sof` on a last-column slot is treated as `sof` (col 0), not row completion.
- `RST` asserted mid-row or mid-handshake: all state returns to reset values immediately, and partial and pending rows are lost.

## Test plan
- Continuous stream, `row_ready` = 1, pixel j = {j[7:0], j[7:0], ~j[7:0]} with `sof` on j = 0 → cycle after beat 255:
  - `row_valid` = 1, `row_num` = 0, `row_first` = 1
  - `row_out[6143:6120]` = 0x0000FF, `row_out[23:0]` = 0xFFFF00
- Backpressure: `row_ready` = 0, stream 512 pixels →
  - row 0 held unchanged
  - `pix_ready` = 0 after pixel 511
  - raise `row_ready` one cycle → next cycle `row_num` = 1 and `pix_ready` = 1
- `sof` at col 100 →
  - `sof_err` one-cycle pulse
  - the next row completes 256 accepted beats after the `sof` beat, and that row has `row_num` = 0
- Full frame of 256 rows →
  - `row_last` = 1 only for `row_num` = 255
  - the following row has `row_num` = 0 and `row_first` = 1
- Random `pix_valid` gaps (50%) → packed rows bit-identical to the gap-free run.
- `RST` pulse at col 37 with a row pending → all outputs at reset values. A fresh 256-pixel row then appears correctly with `row_num` = 0.

Source files
------------

// File: rtl/row_packer_if.sv
// Pixel-in / row-out handshake bundle for row_packer.
// The packer connects through the slave modport; the producer/consumer side uses master.
interface row_packer_if #(
  parameter int ROW   = 256,
  parameter int COL   = 256,
  parameter int WIDTH = 8
);
  localparam int PIX = 3 * WIDTH;
  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;

  logic [PIX-1:0]     pix_in;
  logic               pix_valid;
  logic               sof;
  logic               pix_ready;
  logic [COL*PIX-1:0] row_out;
  logic               row_valid;
  logic               row_ready;
  logic [RW-1:0]      row_num;
  logic               row_first;
  logic               row_last;
  logic               sof_err;

  modport slave (
    input  pix_in, pix_valid, sof, row_ready,
    output pix_ready, row_out, row_valid, row_num, row_first, row_last, sof_err
  );

  modport master (
    output pix_in, pix_valid, sof, row_ready,
    input  pix_ready, row_out, row_valid, row_num, row_first, row_last, sof_err
  );
endinterface

// File: rtl/row_packer.sv
// Packs a raster pixel stream into full rows for median_filter, with a one-deep
// output register plus the assembly buffer acting as a second row of slack.
module row_packer #(
  parameter int ROW   = 256,
  parameter int COL   = 256,
  parameter int WIDTH = 8
) (
  input logic        CLK,
  input logic        RST,
  row_packer_if.slave bus
);
  localparam int PIX = 3 * WIDTH;
  localparam int CW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [COL*PIX-1:0] asm_q, asm_d;
  logic               asm_full_q, asm_full_d;
  logic [RW-1:0]      asm_row_q, asm_row_d;
  logic [COL*PIX-1:0] row_out_q, row_out_d;
  logic               row_valid_q, row_valid_d;
  logic [RW-1:0]      row_num_q, row_num_d;
  logic               row_first_q, row_first_d;
  logic               row_last_q, row_last_d;
  logic               sof_err_q, sof_err_d;

  logic               accept;
  logic               complete;
  logic               slot_free;
  logic [CW-1:0]      eff_col;
  logic [RW-1:0]      eff_row;
  logic [RW-1:0]      next_row;

  assign bus.pix_ready = !asm_full_q;
  assign bus.row_out   = row_out_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_num   = row_num_q;
  assign bus.row_first = row_first_q;
  assign bus.row_last  = row_last_q;
  assign bus.sof_err   = sof_err_q;

  // A sof beat restarts at (row 0, col 0), so it can never complete a row.
  always_comb begin
    accept    = bus.pix_valid && !asm_full_q;
    eff_col   = bus.sof ? '0 : col_q;
    eff_row   = bus.sof ? '0 : row_q;
    complete  = accept && !bus.sof && (col_q == COL_LAST);
    slot_free = !row_valid_q || bus.row_ready;
    next_row  = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;

    col_d       = col_q;
    row_d       = row_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    asm_row_d   = asm_row_q;
    row_out_d   = row_out_q;
    row_valid_d = row_valid_q;
    row_num_d   = row_num_q;
    row_first_d = row_first_q;
    row_last_d  = row_last_q;
    sof_err_d   = accept && bus.sof && (col_q != '0);

    if (accept) begin
      asm_d[COL*PIX-1-PIX*int'(eff_col) -: PIX] = bus.pix_in;
      if (complete) begin
        col_d = '0;
        row_d = next_row;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end

    // A parked row has priority; while it is parked no pixel can complete another.
    if (asm_full_q && bus.row_ready) begin
      row_out_d   = asm_q;
      row_num_d   = asm_row_q;
      row_first_d = (asm_row_q == '0);
      row_last_d  = (asm_row_q == ROW_LAST);
      row_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end else if (complete && slot_free) begin
      row_out_d   = asm_d;
      row_num_d   = eff_row;
      row_first_d = (eff_row == '0);
      row_last_d  = (eff_row == ROW_LAST);
      row_valid_d = 1'b1;
    end else if (complete) begin
      asm_full_d = 1'b1;
      asm_row_d  = eff_row;
    end else if (row_valid_q && bus.row_ready) begin
      row_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_q       <= '0;
      row_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      asm_row_q   <= '0;
      row_out_q   <= '0;
      row_valid_q <= 1'b0;
      row_num_q   <= '0;
      row_first_q <= 1'b0;
      row_last_q  <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      asm_row_q   <= asm_row_d;
      row_out_q   <= row_out_d;
      row_valid_q <= row_valid_d;
      row_num_q   <= row_num_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      sof_err_q   <= sof_err_d;
    end
  end
endmodule

// File: tb/tb_row_packer.sv
// Randomized scoreboard bench for row_packer: the driver feeds a frame-level
// reference model that queues expected rows; a monitor checks each consumed row.
module tb_row_packer;
  localparam int ROW   = 256;
  localparam int COL   = 256;
  localparam int WIDTH = 8;
  localparam int PIX   = 3 * WIDTH;
  localparam int RB    = COL * PIX;

  typedef struct {
    logic [RB-1:0] data;
    int            num;
  } rowT;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rowT            sbQ[$];
  logic [PIX-1:0] rowPix [COL];
  int curCol    = 0;
  int curRow    = 0;
  int total     = 0;
  int bad       = 0;
  int cycleCnt  = 0;
  int errExpAt  = -1;
  int rdyMode   = 0;

  row_packer_if #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) bus ();

  row_packer #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  // Test-plan pixel pattern {j, j, ~j} on the low byte of the stream index.
  function automatic logic [PIX-1:0] pattern(input int j);
    logic [7:0] b;
    b = j[7:0];
    return {b, b, ~b};
  endfunction

  function automatic logic [RB-1:0] patternRow();
    logic [RB-1:0] r;
    r = '0;
    for (int j = 0; j < COL; j++) r = (r << PIX) | RB'(pattern(j));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRow(input string name, input logic [RB-1:0] exp);
    logic [RB-1:0] act;
    int            idx;
    act = bus.row_out;
    total++;
    if (act !== exp) begin
      idx = 0;
      for (int j = COL - 1; j >= 0; j--)
        if (act[RB-1-PIX*j -: PIX] !== exp[RB-1-PIX*j -: PIX]) idx = j;
      bad++;
      $display("[TB] FAIL %s: pixel %0d got 0x%06h, want 0x%06h", name, idx,
               act[RB-1-PIX*idx -: PIX], exp[RB-1-PIX*idx -: PIX]);
    end
  endtask

  // Frame-level model of one accepted beat.
  task automatic modelBeat(input logic s, input logic [PIX-1:0] p);
    rowT e;
    if (s) begin
      if (curCol != 0) errExpAt = cycleCnt + 1;
      curCol = 0;
      curRow = 0;
    end
    rowPix[curCol] = p;
    curCol++;
    if (curCol == COL) begin
      e.data = '0;
      for (int j = 0; j < COL; j++) e.data = (e.data << PIX) | RB'(rowPix[j]);
      e.num = curRow;
      sbQ.push_back(e);
      curCol = 0;
      curRow = (curRow + 1) % ROW;
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, acceptance is
  // decided from pix_ready, which is stable until the next rising edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [PIX-1:0] p, output logic acc);
    @(negedge CLK);
    bus.pix_valid = v && !RST;
    bus.pix_in    = v ? p : PIX'($urandom);
    bus.sof       = v ? s : 1'($urandom);
    bus.row_ready = (rdyMode == 2) ? 1'($urandom) : (rdyMode == 1);
    #1;
    acc = 1'b0;
    if (v && !RST) begin
      checkOutput("pix_ready", 64'(bus.pix_ready), 64'(sbQ.size() < 2));
      acc = bus.pix_ready;
      if (acc) modelBeat(s, p);
    end
  endtask

  task automatic sendPix(input logic [PIX-1:0] p, input logic s, input int pct);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 1000) begin
      applyStimulus($urandom_range(99) < pct, s, p, acc);
      tries++;
    end
    if (!acc) begin
      bad++;
      total++;
      $display("[TB] FAIL accept_timeout: got no acceptance, want one within 1000 cycles");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdyMode = 1;
    while (sbQ.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    idle(2);
    checkOutput("drain_left", 64'(sbQ.size()), 64'd0);
  endtask

  task automatic afterEdge();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_row_valid"}, 64'(bus.row_valid), 64'd0);
    checkOutput({tag, "_row_num"},   64'(bus.row_num),   64'd0);
    checkOutput({tag, "_row_first"}, 64'(bus.row_first), 64'd0);
    checkOutput({tag, "_row_last"},  64'(bus.row_last),  64'd0);
    checkOutput({tag, "_sof_err"},   64'(bus.sof_err),   64'd0);
    checkOutput({tag, "_pix_ready"}, 64'(bus.pix_ready), 64'd1);
    checkRow({tag, "_row_out"}, '0);
  endtask

  // Monitor: compares sof_err every cycle and each consumed row with the queue head.
  initial begin : monitor
    logic expErr;
    rowT  e;
    forever begin
      @(negedge CLK);
      #2;
      if (!RST) begin
        expErr = (cycleCnt == errExpAt);
        if (bus.sof_err || expErr) checkOutput("sof_err", 64'(bus.sof_err), 64'(expErr));
        if (bus.row_valid && bus.row_ready) begin
          if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_row: got row_num %0d, want no row", bus.row_num);
          end else begin
            e = sbQ.pop_front();
            checkRow("row_data", e.data);
            checkOutput("row_num",   64'(bus.row_num),   64'(e.num));
            checkOutput("row_first", 64'(bus.row_first), 64'(e.num == 0));
            checkOutput("row_last",  64'(bus.row_last),  64'(e.num == ROW - 1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(95000 * 10);
    $display("[TB] FAIL watchdog: got no end of test, want finish before 95000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.sof       = 1'b0;
    bus.row_ready = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    afterEdge();
    checkResetState("reset");

    $display("[TB] continuous row with row_ready high");
    rdyMode = 1;
    for (int j = 0; j < COL; j++) sendPix(pattern(j), j == 0, 100);
    afterEdge();
    checkOutput("first_valid", 64'(bus.row_valid), 64'd1);
    checkOutput("first_num",   64'(bus.row_num),   64'd0);
    checkOutput("first_flag",  64'(bus.row_first), 64'd1);
    checkOutput("first_msb",   64'(bus.row_out[RB-1 -: PIX]), 64'h0000FF);
    checkOutput("first_lsb",   64'(bus.row_out[PIX-1:0]),     64'hFFFF00);
    drain();

    $display("[TB] backpressure with two rows buffered");
    rdyMode = 0;
    for (int j = 0; j < 2 * COL; j++) sendPix(pattern(j), j == 0, 100);
    afterEdge();
    checkOutput("bp_pix_ready", 64'(bus.pix_ready), 64'd0);
    checkOutput("bp_valid",     64'(bus.row_valid), 64'd1);
    checkOutput("bp_num",       64'(bus.row_num),   64'd0);
    idle(3);
    checkRow("bp_hold", patternRow());
    rdyMode = 1;
    idle(1);
    rdyMode = 0;
    afterEdge();
    checkOutput("bp_next_num",   64'(bus.row_num),   64'd1);
    checkOutput("bp_next_ready", 64'(bus.pix_ready), 64'd1);
    checkOutput("bp_next_valid", 64'(bus.row_valid), 64'd1);
    drain();

    $display("[TB] sof in the middle of a row");
    rdyMode = 1;
    for (int j = 0; j < 100; j++) sendPix(pattern(j), j == 0, 100);
    sendPix(pattern(0), 1'b1, 100);
    afterEdge();
    checkOutput("sof_pulse_hi", 64'(bus.sof_err), 64'd1);
    idle(1);
    afterEdge();
    checkOutput("sof_pulse_lo", 64'(bus.sof_err), 64'd0);
    for (int j = 1; j < COL; j++) sendPix(pattern(j), 1'b0, 100);
    drain();

    $display("[TB] sof on the last column");
    for (int j = 0; j < COL - 1; j++) sendPix(PIX'($urandom), j == 0, 100);
    sendPix(pattern(7), 1'b1, 100);
    for (int j = 1; j < COL; j++) sendPix(PIX'($urandom), 1'b0, 100);
    drain();

    $display("[TB] full frame plus wrap row");
    rdyMode = 1;
    for (int j = 0; j < (ROW + 1) * COL; j++) sendPix(pattern(j), j == 0, 100);
    drain();

    $display("[TB] random valid gaps and random row_ready");
    rdyMode = 2;
    for (int j = 0; j < 3 * COL; j++) sendPix(pattern(j), j == 0, 50);
    drain();

    $display("[TB] random pixels with occasional sof");
    rdyMode = 2;
    for (int j = 0; j < 1500; j++)
      sendPix(PIX'($urandom), (j == 0) || ($urandom_range(299) == 0), 70);
    drain();

    $display("[TB] reset mid-row with a row pending");
    rdyMode = 0;
    for (int j = 0; j < COL + 37; j++) sendPix(pattern(j), j == 0, 100);
    @(negedge CLK);
    #3;
    RST = 1'b1;
    bus.pix_valid = 1'b0;
    sbQ.delete();
    curCol   = 0;
    curRow   = 0;
    errExpAt = -1;
    #1;
    checkResetState("rst_async");
    idle(2);
    @(negedge CLK);
    RST = 1'b0;
    afterEdge();
    checkResetState("rst_after");
    rdyMode = 1;
    for (int j = 0; j < COL; j++) sendPix(PIX'($urandom), 1'b0, 100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
